// File: rtl/pipeline_drain_sequencer_pkg.sv
// Shared pipeline types for the interrupt drain sequencer.
// Contents:
//   DrainState      - drain FSM state encoding
//   StableCntWidth  - width of the empty-stability counter
//   WdCntWidth      - width of the drain watchdog counter
//   isDraining()    - true for the states in which the pipeline is being emptied
package pipeline_drain_sequencer_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StDrain,
        StSettle,
        StAck,
        StRelease
    } DrainState;

    localparam int unsigned StableCntWidth = 4;
    localparam int unsigned WdCntWidth     = 16;

    function automatic logic isDraining(input DrainState s);
        return (s == StDrain) || (s == StSettle);
    endfunction

endpackage

// File: rtl/pipeline_drain_sequencer.sv
// Interrupt drain sequencer: on a level interrupt request, bubbles the fetch side until every
// pipeline stage has been empty (and no commit flush is running) for EMPTY_STABLE_CYCLES
// consecutive cycles, then pulses irqAck once and waits for the request to drop.
//
// Optional feature: define RSD_DRAIN_WATCHDOG_EN to add a drain watchdog that gives up after
// DRAIN_TIMEOUT_CYCLES cycles in DRAIN/SETTLE, pulsing drainTimeout instead of irqAck.
//
// Ports:
//   clk, rst (async, active-low)
//   irqReq                                   - level interrupt request
//   ifStageEmpty .. activeListEmpty          - per-stage empty flags
//   cmStageFlushUpper                        - commit-stage flush in progress
//   npStageSendBubbleLowerForInterrupt       - fetch bubble request (registered)
//   wholePipelineEmpty                       - AND of the five empty flags (combinational)
//   irqAck                                   - one-cycle drained pulse (registered)
//   drainBusy                                - high in DRAIN, SETTLE, ACK (registered)
//   drainTimeout                             - one-cycle watchdog pulse (registered, or 0)
module pipeline_drain_sequencer
    import pipeline_drain_sequencer_pkg::*;
#(
    parameter int unsigned EMPTY_STABLE_CYCLES  = 2,
    parameter int unsigned DRAIN_TIMEOUT_CYCLES = 1024
) (
    input  logic clk,
    input  logic rst,
    input  logic irqReq,
    input  logic ifStageEmpty,
    input  logic pdStageEmpty,
    input  logic idStageEmpty,
    input  logic rnStageEmpty,
    input  logic activeListEmpty,
    input  logic cmStageFlushUpper,
    output logic npStageSendBubbleLowerForInterrupt,
    output logic wholePipelineEmpty,
    output logic irqAck,
    output logic drainBusy,
    output logic drainTimeout
);

    localparam logic [StableCntWidth-1:0] StableTarget = StableCntWidth'(EMPTY_STABLE_CYCLES);
    localparam logic [StableCntWidth-1:0] StableMax    = '1;

    DrainState stateQ, stateD;
    logic [StableCntWidth-1:0] stableCntQ, stableCntD, stableInc;
    logic bubbleQ, irqAckQ, drainBusyQ;
    logic quietCycle;
    logic wdExpired;

    assign wholePipelineEmpty = ifStageEmpty & pdStageEmpty & idStageEmpty &
                                rnStageEmpty & activeListEmpty;

    // A cycle only counts toward stability if nothing is live and no flush is in flight.
    assign quietCycle = wholePipelineEmpty & ~cmStageFlushUpper;

    assign stableInc = (stableCntQ == StableMax) ? StableMax : stableCntQ + 1'b1;

`ifdef RSD_DRAIN_WATCHDOG_EN
    localparam logic [WdCntWidth-1:0] WdLimit = WdCntWidth'(DRAIN_TIMEOUT_CYCLES - 1);
    localparam logic [WdCntWidth-1:0] WdMax   = '1;

    logic [WdCntWidth-1:0] wdCntQ, wdCntD;
    logic drainTimeoutQ, drainTimeoutD;

    assign wdExpired = isDraining(stateQ) && (wdCntQ == WdLimit);

    // Counts cycles spent continuously in DRAIN/SETTLE; any other state restarts it.
    always_comb begin
        wdCntD = '0;
        if (isDraining(stateQ) && isDraining(stateD)) begin
            wdCntD = (wdCntQ == WdMax) ? WdMax : wdCntQ + 1'b1;
        end
        // Pulse lands in the last draining cycle so RELEASE follows it directly.
        drainTimeoutD = isDraining(stateD) && (wdCntD == WdLimit);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wdCntQ        <= '0;
            drainTimeoutQ <= 1'b0;
        end else begin
            wdCntQ        <= wdCntD;
            drainTimeoutQ <= drainTimeoutD;
        end
    end

    assign drainTimeout = drainTimeoutQ;
`else
    assign wdExpired    = 1'b0;
    assign drainTimeout = 1'b0;
`endif

    // Priority inside DRAIN/SETTLE: withdrawal, then watchdog, then normal progress.
    always_comb begin
        stateD     = stateQ;
        stableCntD = stableCntQ;
        unique case (stateQ)
            StIdle: begin
                if (irqReq) stateD = StDrain;
            end
            StDrain: begin
                if (!irqReq) begin
                    stateD = StIdle;
                end else if (wdExpired) begin
                    stateD = StRelease;
                end else if (quietCycle) begin
                    stableCntD = StableCntWidth'(1);
                    stateD     = (EMPTY_STABLE_CYCLES <= 1) ? StAck : StSettle;
                end
            end
            StSettle: begin
                if (!irqReq) begin
                    stateD = StIdle;
                end else if (wdExpired) begin
                    stateD = StRelease;
                end else if (quietCycle) begin
                    stableCntD = stableInc;
                    if (stableInc >= StableTarget) stateD = StAck;
                end else begin
                    stableCntD = '0;
                    stateD     = StDrain;
                end
            end
            StAck: begin
                stateD = StRelease;
            end
            StRelease: begin
                // Stays here while the acknowledged request is still held.
                if (!irqReq) stateD = StIdle;
            end
            default: begin
                stateD = StIdle;
            end
        endcase
        if (stateD == StIdle || stateD == StRelease) stableCntD = '0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stateQ     <= StIdle;
            stableCntQ <= '0;
            bubbleQ    <= 1'b0;
            irqAckQ    <= 1'b0;
            drainBusyQ <= 1'b0;
        end else begin
            stateQ     <= stateD;
            stableCntQ <= stableCntD;
            bubbleQ    <= isDraining(stateD) || (stateD == StAck);
            irqAckQ    <= (stateD == StAck);
            drainBusyQ <= isDraining(stateD) || (stateD == StAck);
        end
    end

    assign npStageSendBubbleLowerForInterrupt = bubbleQ;
    assign irqAck                             = irqAckQ;
    assign drainBusy                          = drainBusyQ;

endmodule

// File: tb/tb_pipeline_drain_sequencer.sv
// Scoreboard bench for pipeline_drain_sequencer. Each stimulus step drives one cycle of inputs
// and queues the hand-computed state/outputs expected during that cycle; the monitor pops and
// compares mid-cycle (and right after an asynchronous reset edge).
module tb_pipeline_drain_sequencer;
    import pipeline_drain_sequencer_pkg::*;

    localparam logic [4:0] ALL = 5'b11111;
    localparam logic [4:0] RN0 = 5'b11101;
    localparam logic [4:0] AL0 = 5'b11110;
    localparam logic [4:0] NONE_EMPTY = 5'b00000;
    // {bubble, irqAck, drainBusy, drainTimeout}
    localparam logic [3:0] O_NONE = 4'b0000;
    localparam logic [3:0] O_BUSY = 4'b1010;
    localparam logic [3:0] O_ACK  = 4'b1110;
    localparam logic [3:0] O_TMO  = 4'b1011;

    typedef struct {
        int         id;
        logic [11:0] vec;  // {state, stableCnt, bubble, ack, busy, timeout, wholeEmpty}
    } ExpEntry;

    logic clk;
    logic rst;
    logic irqReq;
    logic ifE, pdE, idE, rnE, alE;
    logic flush;
    logic bubble, wpe, ack, busy, tmo;
    logic stimDone;

    ExpEntry expQ[$];
    int checks;
    int fails;
    int wpeChecks;
    int wpeFails;

    pipeline_drain_sequencer #(
        .EMPTY_STABLE_CYCLES (2),
        .DRAIN_TIMEOUT_CYCLES(16)
    ) dut (
        .clk                               (clk),
        .rst                               (rst),
        .irqReq                            (irqReq),
        .ifStageEmpty                      (ifE),
        .pdStageEmpty                      (pdE),
        .idStageEmpty                      (idE),
        .rnStageEmpty                      (rnE),
        .activeListEmpty                   (alE),
        .cmStageFlushUpper                 (flush),
        .npStageSendBubbleLowerForInterrupt(bubble),
        .wholePipelineEmpty                (wpe),
        .irqAck                            (ack),
        .drainBusy                         (busy),
        .drainTimeout                      (tmo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic pushExp(input int id, input logic [4:0] emp, input DrainState st,
                           input logic [3:0] sc, input logic [3:0] outs);
        ExpEntry e;
        e.id  = id;
        e.vec = {st, sc, outs, (emp == ALL)};
        expQ.push_back(e);
    endtask

    task automatic step(input int id, input logic irq, input logic [4:0] emp, input logic fl,
                        input DrainState st, input logic [3:0] sc, input logic [3:0] outs);
        @(posedge clk);
        #1;
        irqReq = irq;
        {ifE, pdE, idE, rnE, alE} = emp;
        flush = fl;
        pushExp(id, emp, st, sc, outs);
    endtask

    initial begin
        wpeChecks = 0;
        wpeFails  = 0;
    end

    // Combinational empty-AND check every cycle
    always @(negedge clk) begin
        #2;
        wpeChecks++;
        if (wpe !== (ifE & pdE & idE & rnE & alE)) begin
            wpeFails++;
            $display("FAIL wholePipelineEmpty at %0t: got %b, want %b", $time, wpe,
                     (ifE & pdE & idE & rnE & alE));
        end
    end

    // Monitor / comparator
    initial begin
        ExpEntry e;
        logic [11:0] act;
        checks = 0;
        fails  = 0;
        while (stimDone !== 1'b1) begin
            @(negedge clk or negedge rst or posedge stimDone);
            #1;
            if (expQ.size() > 0) begin
                e   = expQ.pop_front();
                act = {dut.stateQ, dut.stableCntQ, bubble, ack, busy, tmo, wpe};
                checks++;
                if (act !== e.vec) begin
                    fails++;
                    $display("FAIL step %0d at %0t: got {st,cnt,bub,ack,busy,tmo,wpe}=%b, want %b",
                             e.id, $time, act, e.vec);
                end
            end
        end
        checks++;
        if (expQ.size() != 0) begin
            fails++;
            $display("FAIL scoreboard: got %0d unchecked entries, want 0", expQ.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures",
                 checks + wpeChecks, fails + wpeFails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global time limit reached: got no end of stimulus, want completion");
        $fatal(1, "time limit");
    end

    // Stimulus
    initial begin
        stimDone = 1'b0;
        rst      = 1'b0;
        irqReq   = 1'b0;
        {ifE, pdE, idE, rnE, alE} = NONE_EMPTY;
        flush    = 1'b0;

        // Reset state
        @(posedge clk);
        #1;
        pushExp(0, NONE_EMPTY, StIdle, 4'd0, O_NONE);
        @(negedge clk);
        #3;
        rst = 1'b1;

        // All empty: DRAIN, SETTLE, ACK, RELEASE, then IDLE once the request drops
        step(100, 1'b1, ALL, 1'b0, StIdle,    4'd0, O_NONE);
        step(101, 1'b1, ALL, 1'b0, StDrain,   4'd0, O_BUSY);
        step(102, 1'b1, ALL, 1'b0, StSettle,  4'd1, O_BUSY);
        step(103, 1'b1, ALL, 1'b0, StAck,     4'd2, O_ACK);
        step(104, 1'b1, ALL, 1'b0, StRelease, 4'd0, O_NONE);
        step(105, 1'b1, ALL, 1'b0, StRelease, 4'd0, O_NONE);
        step(106, 1'b0, ALL, 1'b0, StRelease, 4'd0, O_NONE);
        step(107, 1'b0, ALL, 1'b0, StIdle,    4'd0, O_NONE);

        // Rename stage busy for five cycles
        step(200, 1'b1, RN0, 1'b0, StIdle, 4'd0, O_NONE);
        for (int k = 1; k <= 4; k++) step(200 + k, 1'b1, RN0, 1'b0, StDrain, 4'd0, O_BUSY);
        step(205, 1'b1, ALL, 1'b0, StDrain,   4'd0, O_BUSY);
        step(206, 1'b1, ALL, 1'b0, StSettle,  4'd1, O_BUSY);
        step(207, 1'b1, ALL, 1'b0, StAck,     4'd2, O_ACK);
        step(208, 1'b0, ALL, 1'b0, StRelease, 4'd0, O_NONE);
        step(209, 1'b0, ALL, 1'b0, StIdle,    4'd0, O_NONE);

        // Commit flush during SETTLE restarts the stability count
        step(300, 1'b1, ALL, 1'b0, StIdle,    4'd0, O_NONE);
        step(301, 1'b1, ALL, 1'b0, StDrain,   4'd0, O_BUSY);
        step(302, 1'b1, ALL, 1'b1, StSettle,  4'd1, O_BUSY);
        step(303, 1'b1, ALL, 1'b0, StDrain,   4'd0, O_BUSY);
        step(304, 1'b1, ALL, 1'b0, StSettle,  4'd1, O_BUSY);
        step(305, 1'b1, ALL, 1'b0, StAck,     4'd2, O_ACK);
        step(306, 1'b0, ALL, 1'b0, StRelease, 4'd0, O_NONE);
        step(307, 1'b0, ALL, 1'b0, StIdle,    4'd0, O_NONE);

        // Withdrawal in DRAIN
        step(400, 1'b1, RN0, 1'b0, StIdle,  4'd0, O_NONE);
        step(401, 1'b0, RN0, 1'b0, StDrain, 4'd0, O_BUSY);
        step(402, 1'b0, RN0, 1'b0, StIdle,  4'd0, O_NONE);
        step(403, 1'b0, ALL, 1'b0, StIdle,  4'd0, O_NONE);

        // Withdrawal in SETTLE
        step(410, 1'b1, ALL, 1'b0, StIdle,   4'd0, O_NONE);
        step(411, 1'b1, ALL, 1'b0, StDrain,  4'd0, O_BUSY);
        step(412, 1'b0, ALL, 1'b0, StSettle, 4'd1, O_BUSY);
        step(413, 1'b0, ALL, 1'b0, StIdle,   4'd0, O_NONE);

        // Asynchronous reset pulse between edges while in SETTLE
        step(500, 1'b1, ALL, 1'b0, StIdle,   4'd0, O_NONE);
        step(501, 1'b1, ALL, 1'b0, StDrain,  4'd0, O_BUSY);
        step(502, 1'b1, ALL, 1'b0, StSettle, 4'd1, O_BUSY);
        @(negedge clk);
        #2;
        pushExp(503, ALL, StIdle, 4'd0, O_NONE);
        rst = 1'b0;
        #2;
        rst = 1'b1;
        step(504, 1'b1, ALL, 1'b0, StDrain,   4'd0, O_BUSY);
        step(505, 1'b1, ALL, 1'b0, StSettle,  4'd1, O_BUSY);
        step(506, 1'b1, ALL, 1'b0, StAck,     4'd2, O_ACK);
        step(507, 1'b0, ALL, 1'b0, StRelease, 4'd0, O_NONE);
        step(508, 1'b0, ALL, 1'b0, StIdle,    4'd0, O_NONE);

        // Active list stuck non-empty
        step(600, 1'b1, AL0, 1'b0, StIdle, 4'd0, O_NONE);
`ifdef RSD_DRAIN_WATCHDOG_EN
        for (int k = 1; k <= 15; k++) step(600 + k, 1'b1, AL0, 1'b0, StDrain, 4'd0, O_BUSY);
        step(616, 1'b1, AL0, 1'b0, StDrain,   4'd0, O_TMO);
        step(617, 1'b0, AL0, 1'b0, StRelease, 4'd0, O_NONE);
        step(618, 1'b0, AL0, 1'b0, StIdle,    4'd0, O_NONE);
`else
        for (int k = 1; k <= 19; k++) step(600 + k, 1'b1, AL0, 1'b0, StDrain, 4'd0, O_BUSY);
        step(620, 1'b0, AL0, 1'b0, StDrain, 4'd0, O_BUSY);
        step(621, 1'b0, AL0, 1'b0, StIdle,  4'd0, O_NONE);
`endif

        @(negedge clk);
        #3;
        stimDone = 1'b1;
    end

endmodule

// File: doc/pipeline_drain_sequencer.md
PIPELINE_DRAIN_SEQUENCER -- requirements
Module: pipeline_drain_sequencer

Interface
REQ-001 SHALL have parameter EMPTY_STABLE_CYCLES, default 2: consecutive all-empty cycles required before acknowledging (range 1..15).
REQ-002 SHALL have parameter DRAIN_TIMEOUT_CYCLES, default 1024: watchdog limit in cycles (range 2..65535).
REQ-003 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, asynchronous and active-low.
REQ-005 SHALL have port irqReq, input, 1 bit: level interrupt request; held high until irqAck or drainTimeout is observed.
REQ-006 SHALL have ports ifStageEmpty, pdStageEmpty, idStageEmpty, rnStageEmpty and activeListEmpty, each input, 1 bit: per-stage no-live-instruction flags.
REQ-007 SHALL have port cmStageFlushUpper, input, 1 bit: commit-stage flush in progress.
REQ-008 SHALL have port npStageSendBubbleLowerForInterrupt, output, 1 bit: fetch-side bubble request to the controller.
REQ-009 SHALL have port wholePipelineEmpty, output, 1 bit: AND of the five empty inputs.
REQ-010 SHALL have port irqAck, output, 1 bit: one-cycle pulse; pipeline drained, interrupt may be taken.
REQ-011 SHALL have port drainBusy, output, 1 bit: high in DRAIN, SETTLE or ACK.
REQ-012 SHALL have port drainTimeout, output, 1 bit: one-cycle watchdog pulse; constant 0 when the watchdog is compiled out.

Function
REQ-013 SHALL compute wholePipelineEmpty combinationally, with 0 latency.
REQ-014 SHALL implement FSM states IDLE, DRAIN, SETTLE, ACK and RELEASE, one state per cycle.
REQ-015 IDLE: SHALL move to DRAIN the cycle after irqReq=1 is sampled; all outputs except wholePipelineEmpty SHALL be 0.
REQ-016 DRAIN: SHALL assert bubble; with wholePipelineEmpty=1 and cmStageFlushUpper=0, SHALL load stableCnt=1 and go to SETTLE (go straight to ACK if EMPTY_STABLE_CYCLES=1).
REQ-017 SETTLE: SHALL assert bubble; with empty and no flush, SHALL increment stableCnt and go to ACK when stableCnt+1 reaches EMPTY_STABLE_CYCLES; on any non-empty or flush cycle, SHALL clear stableCnt and return to DRAIN.
REQ-018 ACK: SHALL assert irqAck and bubble for exactly one cycle, then go to RELEASE.
REQ-019 RELEASE: bubble SHALL be 0; SHALL go to IDLE when irqReq=0 is sampled; SHALL never re-acknowledge a request that is still held.
REQ-020 SHALL treat irqReq=0 sampled in DRAIN or SETTLE as a withdrawal: go to IDLE, no irqAck.
REQ-021 SHALL give withdrawal priority over timeout, and timeout priority over a same-cycle SETTLE->ACK transition.
REQ-022 SHALL keep stableCnt 4 bits wide, saturating; it SHALL never wrap.

Reset
REQ-023 SHALL force state=IDLE, stableCnt=0, wdCnt=0 and irqAck=drainTimeout=bubble=0 immediately on rst=0, independent of clk, including mid-drain.
REQ-024 SHALL treat the first rising edge after rst deasserts as an IDLE cycle.

Configuration
REQ-025 With RSD_DRAIN_WATCHDOG_EN defined, SHALL count a 16-bit wdCnt up in DRAIN and SETTLE, clear it elsewhere, and on wdCnt=DRAIN_TIMEOUT_CYCLES-1 pulse drainTimeout for one cycle and go to RELEASE without irqAck.
REQ-026 Without RSD_DRAIN_WATCHDOG_EN, SHALL have no wdCnt, tie drainTimeout to 0, and allow DRAIN to last indefinitely.

Structure
REQ-027 SHALL place the DrainState enum typedef and the stable-count and watchdog width constants in the shared PipelineTypes package.
REQ-028 SHALL use no sub-module; FSM, counters and the empty-AND are flat in pipeline_drain_sequencer; the ControllerIF InterruptController modport SHALL connect to it.

Verification
REQ-029 With all empties=1 and irqReq raised at cycle 0, the bench SHALL see bubble at cycle 1, SETTLE at 2, irqAck=1 only at cycle 3, RELEASE at 4, and IDLE after irqReq drops.
REQ-030 With rnStageEmpty=0 for 5 cycles then 1, the bench SHALL see irqAck exactly 2 cycles after the drop plus 1 (EMPTY_STABLE_CYCLES=2), and bubble held throughout.
REQ-031 With cmStageFlushUpper=1 during SETTLE, the bench SHALL see a return to DRAIN, stableCnt=0, and irqAck delayed by at least 2 more cycles.
REQ-032 With irqReq dropped in DRAIN, the bench SHALL see IDLE next cycle, no irqAck ever, and bubble=0.
REQ-033 With RSD_DRAIN_WATCHDOG_EN and DRAIN_TIMEOUT_CYCLES=16 and activeListEmpty stuck 0, the bench SHALL see drainTimeout pulse at the 16th DRAIN cycle, no irqAck, and RELEASE next.
REQ-034 With rst=0 asserted mid-SETTLE between clock edges, the bench SHALL see all outputs 0 immediately, and after release a held irqReq SHALL restart from DRAIN.
